// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU data port.
// Accepts one request at a time, inserts WAIT_CYCLES wait states, then
// completes with a one-cycle ack. Reads return data in a registered rdata.
// Writes are byte-lane masked. Misaligned accesses complete with err=1.
module dmem_responder #(
  parameter int unsigned ROWS        = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDXW = $clog2(ROWS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  // Request fields captured at the accept edge
  logic            we_q;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      lo_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;

  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [ROWS];

  logic            accept;
  logic            commit;
  logic            mem_wr;

  logic            op_we;
  logic [IDXW-1:0] op_idx;
  logic [1:0]      op_lo;
  logic [31:0]     op_wdata;
  logic [3:0]      op_be;
  logic            op_aligned;
  logic [31:0]     wr_word;

  logic            unused_addr;
  assign unused_addr = ^addr[31:IDXW+2];

  assign accept = (state_q == S_IDLE) && req;

  // The memory operation happens on the edge that enters ACK. With zero
  // wait states that edge is also the accept edge, so the operands come
  // straight from the ports that are being captured on that same edge.
  assign commit = (accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // Operand select: live ports when committing on the accept edge, else captured
  always_comb begin
    if (state_q == S_IDLE) begin
      op_we    = we;
      op_idx   = addr[IDXW+1:2];
      op_lo    = addr[1:0];
      op_wdata = wdata;
      op_be    = be;
    end else begin
      op_we    = we_q;
      op_idx   = idx_q;
      op_lo    = lo_q;
      op_wdata = wdata_q;
      op_be    = be_q;
    end
  end

  assign op_aligned = (op_lo == 2'b00);

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Completion datapath: read data, error flag and write strobe
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_wr  = 1'b0;
    if (state_q == S_ACK) begin
      err_d = 1'b0;
    end
    if (commit) begin
      err_d = !op_aligned;
      if (op_aligned) begin
        if (op_we) begin
          mem_wr = 1'b1;
        end else begin
          rdata_d = mem_q[op_idx];
        end
      end
    end
  end

  // Byte-lane merge of write data into the addressed word
  always_comb begin
    wr_word = mem_q[op_idx];
    for (int unsigned b = 0; b < 4; b++) begin
      if (op_be[b]) begin
        wr_word[8*b +: 8] = op_wdata[8*b +: 8];
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture request fields at the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= we;
      idx_q   <= addr[IDXW+1:2];
      lo_q    <= addr[1:0];
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  // Storage array, deliberately not reset; writes are blocked while rst is held
  always_ff @(posedge clk) begin
    if (mem_wr && !rst) begin
      mem_q[op_idx] <= wr_word;
    end
  end

  assign rdata = rdata_q;
  assign ack   = (state_q == S_ACK);
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait
// states and one with none, both compared against a word-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic        we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] model [2][32];
  logic [31:0] exp_rdata [2];
  int unsigned wait_of [2] = '{2, 0};

  always #5 clk = ~clk;

  dmem_responder #(.ROWS(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_i), .addr(addr_i),
    .wdata(wdata_i), .be(be_i), .rdata(rdata_a), .ack(ack_a),
    .err(err_a), .busy(busy_a)
  );

  dmem_responder #(.ROWS(32), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_i), .addr(addr_i),
    .wdata(wdata_i), .be(be_i), .rdata(rdata_b), .ack(ack_b),
    .err(err_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input int s);
    return (s == 0) ? rdata_a : rdata_b;
  endfunction
  function automatic logic ack_of(input int s);
    return (s == 0) ? ack_a : ack_b;
  endfunction
  function automatic logic err_of(input int s);
    return (s == 0) ? err_a : err_b;
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [31:0] mem_of(input int s, input int unsigned i);
    return (s == 0) ? dut_a.mem_q[i] : dut_b.mem_q[i];
  endfunction

  task automatic set_req(input int s, input logic v);
    if (s == 0) req_a = v;
    else        req_b = v;
  endtask

  // One complete transfer on instance s; inputs are scrambled after the
  // accept edge. Optionally asserts reset during the ack cycle.
  task automatic xfer(input int s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input bit rst_at_ack);
    int unsigned n;
    bit got;
    int unsigned idx;
    logic [31:0] mask;
    idx = int'(a[6:2]);
    @(negedge clk);
    check("idle_busy", 32'(busy_of(s)), 32'd0);
    check("idle_ack", 32'(ack_of(s)), 32'd0);
    we_i = w; addr_i = a; wdata_i = d; be_i = b;
    set_req(s, 1'b1);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack_of(s)) begin
        got = 1;
      end else begin
        check("wait_busy", 32'(busy_of(s)), 32'd1);
      end
      we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom);
    end
    check("ack_latency", 32'(n), 32'(wait_of[s] + 1));
    if (got) begin
      check("ack_busy", 32'(busy_of(s)), 32'd1);
      if (a[1:0] != 2'b00) begin
        check("err_mis", 32'(err_of(s)), 32'd1);
      end else begin
        check("err_ok", 32'(err_of(s)), 32'd0);
        if (w) begin
          mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
          model[s][idx] = (model[s][idx] & ~mask) | (d & mask);
        end else begin
          exp_rdata[s] = model[s][idx];
        end
      end
      check("rdata", rdata_of(s), exp_rdata[s]);
    end
    set_req(s, 1'b0);
    if (rst_at_ack) begin
      rst = 1'b1;
      #1;
      check("rst_ack_clr", 32'(ack_of(s)), 32'd0);
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      @(negedge clk);
      rst = 1'b0;
    end
    check("mem_backdoor", mem_of(s, idx), model[s][idx]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, saved;
    logic w;
    rst = 1'b1; req_a = 0; req_b = 0; we_i = 0; addr_i = 0; wdata_i = 0; be_i = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ack", 32'(ack_of(s)), 32'd0);
      check("rst_err", 32'(err_of(s)), 32'd0);
      check("rst_busy", 32'(busy_of(s)), 32'd0);
      check("rst_rdata", rdata_of(s), 32'd0);
    end
    rst = 1'b0;

    // Preload every word through the port so the model is fully known
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++)
        xfer(s, 1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    // Basic write/read at addr 4
    xfer(0, 1'b1, 32'd4, 32'h0000_7F7F, 4'hF, 0);
    xfer(0, 1'b0, 32'd4, 32'h0, 4'h0, 0);
    check("wr_rd_4", rdata_a, 32'h0000_7F7F);

    // Index wrap and top word
    xfer(0, 1'b1, 32'd0, 32'hF7F7_7F7F, 4'hF, 0);
    xfer(0, 1'b0, 32'd128, 32'h0, 4'h0, 0);
    check("wrap_128", rdata_a, 32'hF7F7_7F7F);
    xfer(0, 1'b1, 32'd124, 32'h8888_8888, 4'hF, 0);
    check("mem31", dut_a.mem_q[31], 32'h8888_8888);
    xfer(0, 1'b0, 32'd124, 32'h0, 4'h0, 0);
    check("rd_124", rdata_a, 32'h8888_8888);

    // Single byte lane
    xfer(0, 1'b1, 32'd8, 32'hFFFF_FFFF, 4'hF, 0);
    xfer(0, 1'b1, 32'd8, 32'h1234_5678, 4'b0100, 0);
    xfer(0, 1'b0, 32'd8, 32'h0, 4'h0, 0);
    check("lane2", rdata_a, 32'hFF34_FFFF);

    // Misaligned write leaves memory and rdata alone
    saved = dut_a.mem_q[1];
    xfer(0, 1'b1, 32'd6, 32'hDEAD_BEEF, 4'hF, 0);
    check("mis_mem1", dut_a.mem_q[1], saved);
    check("mis_rdata", rdata_a, 32'hFF34_FFFF);

    // Empty byte mask
    xfer(0, 1'b1, 32'd12, 32'hCAFE_F00D, 4'h0, 0);

    // Reset one cycle after accept aborts the write
    saved = dut_a.mem_q[0];
    @(negedge clk);
    we_i = 1'b1; addr_i = 32'd0; wdata_i = 32'h1111_2222; be_i = 4'hF; req_a = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_rdata", rdata_a, 32'd0);
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    req_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_noack_rst", 32'(ack_a), 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_noack", 32'(ack_a), 32'd0);
      check("abort_idle", 32'(busy_a), 32'd0);
    end
    check("abort_mem0", dut_a.mem_q[0], saved);

    // Reset during ack keeps a committed write
    xfer(0, 1'b1, 32'd20, 32'h5A5A_A5A5, 4'hF, 1);
    check("ack_rst_mem5", dut_a.mem_q[5], 32'h5A5A_A5A5);
    xfer(1, 1'b1, 32'd24, 32'h0BAD_F00D, 4'hF, 1);

    // Zero-wait instance: back-to-back traffic
    xfer(1, 1'b1, 32'd16, 32'h0102_0304, 4'hF, 0);
    xfer(1, 1'b0, 32'd16, 32'h0, 4'h0, 0);
    check("w0_rd", rdata_b, 32'h0102_0304);
    xfer(1, 1'b1, 32'd17, 32'h0, 4'hF, 0);

    // Randomized traffic on both instances
    for (int i = 0; i < 300; i++) begin
      a = {$urandom_range(0, 7) == 0 ? 25'($urandom) : 25'd0, 5'($urandom), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = 1'($urandom);
      xfer(i % 2, w, a, $urandom, 4'($urandom), 0);
    end

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++)
        check("final_mem", mem_of(s, i), model[s][i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
